// File: rtl/ysyx_23060061_axil_sram_responder.sv
// AXI4-Lite SRAM responder: one outstanding transaction, response delayed by
// a per-transaction latency drawn from a free-running LFSR (or a fixed value).
module ysyx_23060061_axil_sram_responder #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 10,
   parameter int LAT_BITS   = 4,
   parameter int RAND_EN    = 1,
   parameter int FIXED_LAT  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     araddr,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [DATA_W-1:0]     rdata,
   output logic [1:0]            rresp,
   output logic                  rvalid,
   input  logic                  rready,
   input  logic [ADDR_W-1:0]     awaddr,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam int         DEPTH       = 1 << DEPTH_LOG2;

   typedef enum logic [2:0] {
      IDLE,
      R_WAIT,
      R_RESP,
      W_WAIT,
      B_RESP
   } state_e;

   state_e                 state_q;
   logic [LAT_BITS-1:0]    lfsr_q;
   logic [LAT_BITS-1:0]    lfsr_d;
   logic [LAT_BITS-1:0]    cnt_q;
   logic                   lastWrite_q;
   logic [DEPTH_LOG2-1:0]  rdIdx_q;
   logic [1:0]             rdResp_q;
   logic [DATA_W-1:0]      rdata_q;
   logic [1:0]             rresp_q;
   logic                   rvalid_q;
   logic [1:0]             bresp_q;
   logic                   bvalid_q;

   logic [DATA_W-1:0]      mem [DEPTH];

   logic                   idle;
   logic                   rdReq;
   logic                   wrReq;
   logic                   grantRd;
   logic                   grantWr;
   logic                   wrCommit;
   logic [LAT_BITS-1:0]    latSel;
   logic [DEPTH_LOG2-1:0]  arIdx;
   logic [DEPTH_LOG2-1:0]  awIdx;
   logic [1:0]             arResp;
   logic [1:0]             awResp;

   function automatic logic [1:0] addrResp(input logic [ADDR_W-1:0] a);
      if (a[1:0] != 2'b00) begin
         return RESP_SLVERR;
      end
      if (a[ADDR_W-1:DEPTH_LOG2+2] != '0) begin
         return RESP_DECERR;
      end
      return RESP_OKAY;
   endfunction

   assign lfsr_d = {lfsr_q[LAT_BITS-2:0], lfsr_q[LAT_BITS-1] ^ lfsr_q[LAT_BITS-2]};
   assign latSel = (RAND_EN != 0) ? lfsr_q : LAT_BITS'(FIXED_LAT);

   assign arIdx  = araddr[DEPTH_LOG2+1:2];
   assign awIdx  = awaddr[DEPTH_LOG2+1:2];
   assign arResp = addrResp(araddr);
   assign awResp = addrResp(awaddr);

   // Round-robin between read and write: when both ask, the side not served last wins.
   assign idle    = rst && (state_q == IDLE);
   assign rdReq   = arvalid;
   assign wrReq   = awvalid && wvalid;
   assign grantRd = idle && rdReq && (!wrReq || lastWrite_q);
   assign grantWr = idle && wrReq && (!rdReq || !lastWrite_q);

   assign arready = grantRd;
   assign awready = grantWr;
   assign wready  = grantWr;

   assign wrCommit = grantWr && (awResp == RESP_OKAY);

   assign rdata  = rdata_q;
   assign rresp  = rresp_q;
   assign rvalid = rvalid_q;
   assign bresp  = bresp_q;
   assign bvalid = bvalid_q;

   // Memory array is deliberately not reset so committed writes survive a reset.
   always_ff @(posedge clk) begin
      if (wrCommit) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (wstrb[b]) begin
               mem[awIdx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         lfsr_q      <= '1;
         cnt_q       <= '0;
         lastWrite_q <= 1'b1;
         rdIdx_q     <= '0;
         rdResp_q    <= RESP_OKAY;
         rdata_q     <= '0;
         rresp_q     <= RESP_OKAY;
         rvalid_q    <= 1'b0;
         bresp_q     <= RESP_OKAY;
         bvalid_q    <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         case (state_q)
            IDLE: begin
               if (grantRd) begin
                  rdIdx_q  <= arIdx;
                  rdResp_q <= arResp;
                  if (latSel != '0) begin
                     cnt_q   <= latSel;
                     state_q <= R_WAIT;
                  end else begin
                     rdata_q  <= (arResp == RESP_OKAY) ? mem[arIdx] : '0;
                     rresp_q  <= arResp;
                     rvalid_q <= 1'b1;
                     state_q  <= R_RESP;
                  end
               end else if (grantWr) begin
                  bresp_q <= awResp;
                  if (latSel != '0) begin
                     cnt_q   <= latSel;
                     state_q <= W_WAIT;
                  end else begin
                     bvalid_q <= 1'b1;
                     state_q  <= B_RESP;
                  end
               end
            end
            R_WAIT: begin
               cnt_q <= cnt_q - LAT_BITS'(1);
               if (cnt_q == LAT_BITS'(1)) begin
                  rdata_q  <= (rdResp_q == RESP_OKAY) ? mem[rdIdx_q] : '0;
                  rresp_q  <= rdResp_q;
                  rvalid_q <= 1'b1;
                  state_q  <= R_RESP;
               end
            end
            R_RESP: begin
               if (rready) begin
                  rvalid_q    <= 1'b0;
                  lastWrite_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            W_WAIT: begin
               cnt_q <= cnt_q - LAT_BITS'(1);
               if (cnt_q == LAT_BITS'(1)) begin
                  bvalid_q <= 1'b1;
                  state_q  <= B_RESP;
               end
            end
            B_RESP: begin
               if (bready) begin
                  bvalid_q    <= 1'b0;
                  lastWrite_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060061_axil_sram_responder.sv
// Directed bench: a random-latency responder and a fixed-latency (3) responder
// share clock and reset; each scenario task checks its own results.
module tb_ysyx_23060061_axil_sram_responder;

   logic clk = 1'b0;
   logic rst;

   logic [31:0] r_araddr = '0, r_awaddr = '0, r_wdata = '0, r_rdata;
   logic [3:0]  r_wstrb = '0;
   logic        r_arvalid = 0, r_arready, r_rvalid, r_rready = 0;
   logic        r_awvalid = 0, r_awready, r_wvalid = 0, r_wready, r_bvalid, r_bready = 0;
   logic [1:0]  r_rresp, r_bresp;

   logic [31:0] f_araddr = '0, f_awaddr = '0, f_wdata = '0, f_rdata;
   logic [3:0]  f_wstrb = '0;
   logic        f_arvalid = 0, f_arready, f_rvalid, f_rready = 0;
   logic        f_awvalid = 0, f_awready, f_wvalid = 0, f_wready, f_bvalid, f_bready = 0;
   logic [1:0]  f_rresp, f_bresp;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ysyx_23060061_axil_sram_responder u_rand (
      .clk(clk), .rst(rst),
      .araddr(r_araddr), .arvalid(r_arvalid), .arready(r_arready),
      .rdata(r_rdata), .rresp(r_rresp), .rvalid(r_rvalid), .rready(r_rready),
      .awaddr(r_awaddr), .awvalid(r_awvalid), .awready(r_awready),
      .wdata(r_wdata), .wstrb(r_wstrb), .wvalid(r_wvalid), .wready(r_wready),
      .bresp(r_bresp), .bvalid(r_bvalid), .bready(r_bready)
   );

   ysyx_23060061_axil_sram_responder #(.RAND_EN(0), .FIXED_LAT(3)) u_fix (
      .clk(clk), .rst(rst),
      .araddr(f_araddr), .arvalid(f_arvalid), .arready(f_arready),
      .rdata(f_rdata), .rresp(f_rresp), .rvalid(f_rvalid), .rready(f_rready),
      .awaddr(f_awaddr), .awvalid(f_awvalid), .awready(f_awready),
      .wdata(f_wdata), .wstrb(f_wstrb), .wvalid(f_wvalid), .wready(f_wready),
      .bresp(f_bresp), .bvalid(f_bvalid), .bready(f_bready)
   );

   // Drivers start and end at posedge+1; lat counts cycles from accept to bvalid/rvalid.
   task automatic f_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic [1:0] resp);
      int n;
      f_awaddr = a; f_wdata = d; f_wstrb = s;
      f_awvalid = 1; f_wvalid = 1; f_bready = 1;
      lat = -1; resp = 2'bxx; n = 0;
      @(negedge clk);
      while (!(f_awready && f_wready) && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) begin f_awvalid = 0; f_wvalid = 0; return; end
      @(posedge clk); #1;
      f_awvalid = 0; f_wvalid = 0;
      n = 1;
      @(negedge clk);
      while (!f_bvalid && n < 40) begin @(negedge clk); n++; end
      if (f_bvalid) begin lat = n; resp = f_bresp; end
      @(posedge clk); #1;
   endtask

   task automatic f_read(input logic [31:0] a, output int lat, output logic [31:0] data,
                         output logic [1:0] resp);
      int n;
      f_araddr = a; f_arvalid = 1; f_rready = 1;
      lat = -1; data = 'x; resp = 2'bxx; n = 0;
      @(negedge clk);
      while (!f_arready && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) begin f_arvalid = 0; return; end
      @(posedge clk); #1;
      f_arvalid = 0;
      n = 1;
      @(negedge clk);
      while (!f_rvalid && n < 40) begin @(negedge clk); n++; end
      if (f_rvalid) begin lat = n; data = f_rdata; resp = f_rresp; end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      r_arvalid = 1; f_awvalid = 1; f_wvalid = 1; f_arvalid = 1;
      #1;
      vectors++; if (r_arready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_arready got %b want 0", r_arready); end
      vectors++; if (f_awready !== 1'b0 || f_wready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_awready got %b%b want 00", f_awready, f_wready); end
      vectors++; if (r_rvalid !== 1'b0 || f_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rvalid got %b%b want 00", r_rvalid, f_rvalid); end
      vectors++; if (r_bvalid !== 1'b0 || f_bvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_bvalid got %b%b want 00", r_bvalid, f_bvalid); end
      vectors++; if (f_rdata !== 32'h0 || f_rresp !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_rdata got %h/%b want 0/00", f_rdata, f_rresp); end
      vectors++; if (f_bresp !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_bresp got %b want 00", f_bresp); end
      r_arvalid = 0; f_awvalid = 0; f_wvalid = 0; f_arvalid = 0;
   endtask

   // Model LFSR tracked from reset release; each accept must latch its current value.
   task automatic test_lfsr_sequence();
      logic [3:0] m;
      int since, expL, acc, busyReady;
      bit busy;
      r_araddr = 32'h0; r_arvalid = 1; r_rready = 1;
      @(posedge clk); #1;
      rst = 1;
      m = 4'hF; since = 0; expL = 0; acc = 0; busy = 0; busyReady = 0;
      for (int c = 0; c < 200 && acc < 8; c++) begin
         @(negedge clk);
         if (busy) begin
            since++;
            if (r_arready) busyReady++;
            if (r_rvalid) begin
               vectors++;
               if (since !== expL + 1) begin
                  miscompares++;
                  $display("[TB] FAIL lfsr_latency[%0d] got %0d want %0d", acc, since, expL + 1);
               end
               busy = 0; acc++;
            end
         end else if (r_arready) begin
            expL = int'(m); busy = 1; since = 0;
         end
         @(posedge clk);
         m = {m[2:0], m[3] ^ m[2]};
      end
      #1;
      r_arvalid = 0;
      vectors++;
      if (acc !== 8) begin miscompares++; $display("[TB] FAIL lfsr_accepts got %0d want 8", acc); end
      vectors++;
      if (busyReady !== 0) begin miscompares++; $display("[TB] FAIL lfsr_ready_busy got %0d want 0", busyReady); end
   endtask

   task automatic test_fixed_write_read();
      int lat; logic [1:0] resp; logic [31:0] data;
      f_write(32'h10, 32'hDEADBEEF, 4'b1111, lat, resp);
      vectors++; if (lat !== 4) begin miscompares++; $display("[TB] FAIL fix_wr_lat got %0d want 4", lat); end
      vectors++; if (resp !== 2'b00) begin miscompares++; $display("[TB] FAIL fix_wr_bresp got %b want 00", resp); end
      f_read(32'h10, lat, data, resp);
      vectors++; if (lat !== 4) begin miscompares++; $display("[TB] FAIL fix_rd_lat got %0d want 4", lat); end
      vectors++; if (data !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL fix_rd_data got %h want deadbeef", data); end
      vectors++; if (resp !== 2'b00) begin miscompares++; $display("[TB] FAIL fix_rd_rresp got %b want 00", resp); end
   endtask

   task automatic test_byte_strobes();
      int lat; logic [1:0] resp; logic [31:0] data;
      f_write(32'h20, 32'h11223344, 4'b1111, lat, resp);
      vectors++; if (resp !== 2'b00) begin miscompares++; $display("[TB] FAIL strb_wr1 got %b want 00", resp); end
      f_write(32'h20, 32'hAABBCCDD, 4'b0101, lat, resp);
      vectors++; if (resp !== 2'b00) begin miscompares++; $display("[TB] FAIL strb_wr2 got %b want 00", resp); end
      f_read(32'h20, lat, data, resp);
      vectors++; if (data !== 32'h11BB33DD) begin miscompares++; $display("[TB] FAIL strb_rd got %h want 11bb33dd", data); end
   endtask

   task automatic test_errors();
      int lat; logic [1:0] resp; logic [31:0] data;
      f_write(32'h4, 32'hCAFEF00D, 4'b1111, lat, resp);
      vectors++; if (resp !== 2'b00) begin miscompares++; $display("[TB] FAIL err_prewrite got %b want 00", resp); end
      f_read(32'h22, lat, data, resp);
      vectors++; if (resp !== 2'b10 || data !== 32'h0) begin miscompares++; $display("[TB] FAIL err_slverr got %b/%h want 10/0", resp, data); end
      f_read(32'h1000, lat, data, resp);
      vectors++; if (resp !== 2'b11 || data !== 32'h0) begin miscompares++; $display("[TB] FAIL err_decerr got %b/%h want 11/0", resp, data); end
      f_write(32'h1004, 32'h24, 4'b0001, lat, resp);
      vectors++; if (resp !== 2'b11) begin miscompares++; $display("[TB] FAIL err_wr_decerr got %b want 11", resp); end
      f_read(32'h4, lat, data, resp);
      vectors++; if (data !== 32'hCAFEF00D || resp !== 2'b00) begin miscompares++; $display("[TB] FAIL err_unchanged got %h/%b want cafef00d/00", data, resp); end
   endtask

   task automatic test_backpressure_reset();
      int n, bad, lat; logic [1:0] resp; logic [31:0] data;
      f_araddr = 32'h10; f_arvalid = 1; f_rready = 0; n = 0;
      @(negedge clk);
      while (!f_arready && n < 40) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      f_arvalid = 0; n = 0;
      @(negedge clk);
      while (!f_rvalid && n < 40) begin @(negedge clk); n++; end
      vectors++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL bp_first got %b/%h want 1/deadbeef", f_rvalid, f_rdata); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF || f_rresp !== 2'b00) bad++;
      end
      vectors++; if (bad !== 0) begin miscompares++; $display("[TB] FAIL bp_stable got %0d unstable cycles want 0", bad); end
      #2; rst = 0; #1;
      vectors++; if (f_rvalid !== 1'b0 || f_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL bp_reset got %b/%h want 0/0", f_rvalid, f_rdata); end
      @(posedge clk); #1; rst = 1;

      f_awaddr = 32'h40; f_wdata = 32'h5A5A5A5A; f_wstrb = 4'hF;
      f_awvalid = 1; f_wvalid = 1; f_bready = 1; n = 0;
      @(negedge clk);
      while (!f_awready && n < 40) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      f_awvalid = 0; f_wvalid = 0;
      @(negedge clk); rst = 0; #1;
      vectors++; if (f_bvalid !== 1'b0 || f_awready !== 1'b0) begin miscompares++; $display("[TB] FAIL wwait_reset got %b%b want 00", f_bvalid, f_awready); end
      @(posedge clk); #1; rst = 1;

      r_araddr = 32'h0; r_arvalid = 1; r_rready = 1;
      rst = 0;
      @(posedge clk); #1; rst = 1;
      @(negedge clk);
      vectors++; if (r_arready !== 1'b1) begin miscompares++; $display("[TB] FAIL rwait_accept got %b want 1", r_arready); end
      repeat (4) @(negedge clk);
      rst = 0; #1;
      vectors++; if (r_rvalid !== 1'b0 || r_arready !== 1'b0) begin miscompares++; $display("[TB] FAIL rwait_reset got %b%b want 00", r_rvalid, r_arready); end
      @(posedge clk); #1; rst = 1;
      @(negedge clk);
      vectors++; if (r_arready !== 1'b1) begin miscompares++; $display("[TB] FAIL rwait_idle got %b want 1", r_arready); end
      n = 0;
      @(negedge clk); n = 1;
      while (!r_rvalid && n < 40) begin @(negedge clk); n++; end
      vectors++; if (n !== 16) begin miscompares++; $display("[TB] FAIL rwait_lfsr_restart got %0d want 16", n); end
      @(posedge clk); #1;
      r_arvalid = 0;

      f_read(32'h40, lat, data, resp);
      vectors++; if (data !== 32'h5A5A5A5A || resp !== 2'b00) begin miscompares++; $display("[TB] FAIL committed_kept got %h/%b want 5a5a5a5a/00", data, resp); end
   endtask

   task automatic test_contention();
      int g, both, split;
      string want, got;
      rst = 0;
      r_araddr = 32'h8; r_awaddr = 32'hC; r_wdata = 32'h12345678; r_wstrb = 4'hF;
      r_arvalid = 1; r_awvalid = 1; r_wvalid = 1; r_rready = 1; r_bready = 1;
      @(posedge clk); #1; rst = 1;
      g = 0; both = 0; split = 0;
      for (int c = 0; c < 300 && g < 6; c++) begin
         @(negedge clk);
         if (r_arready && r_awready) both++;
         if (r_awready !== r_wready) split++;
         if (r_arready || r_awready) begin
            want = (g % 2 == 0) ? "R" : "W";
            got  = r_arready ? "R" : "W";
            vectors++;
            if (got != want) begin miscompares++; $display("[TB] FAIL grant[%0d] got %s want %s", g, got, want); end
            g++;
         end
      end
      r_arvalid = 0; r_awvalid = 0; r_wvalid = 0;
      vectors++; if (g !== 6) begin miscompares++; $display("[TB] FAIL grant_count got %0d want 6", g); end
      vectors++; if (both !== 0 || split !== 0) begin miscompares++; $display("[TB] FAIL grant_exclusive got %0d/%0d want 0/0", both, split); end
   endtask

   initial begin
      rst = 1;
      #2 rst = 0;
      repeat (2) @(posedge clk);
      test_reset();
      test_lfsr_sequence();
      test_fixed_write_read();
      test_byte_strobes();
      test_errors();
      test_backpressure_reset();
      test_contention();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
